output_16: RTL and testbench

- Transmit-side counterpart of the 16-bit calculator's tagged input bus.
- Captures a finished 16-bit result and a 4-bit flag nibble on a one-cycle `done` pulse.
- Serialises them onto a 10-bit tagged output bus as high byte, low byte, then status, with idle gaps between beats.
- Sits between the ALU/result register and the chip output pins; holds a one-deep pending buffer so a back-to-back `done` is not lost.

---
 rtl/output_16.sv | 184 ++++++++++++++++++
 tb/tb_output_16.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_16.sv
// ============================================================================
// Module   : output_16
// Purpose  : Serialises a captured 16-bit result plus flag nibble onto a
//            10-bit tagged output bus (high byte, low byte, status) with
//            idle gaps and a one-deep pending buffer.
// Options  : `define OUT_PARITY_EN puts result parity in status bit 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_16 #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] result,
  input  logic [3:0]  flags,
  input  logic        done,
  output logic [9:0]  out,
  output logic        busy,
  output logic        pending,
  output logic        lost
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    STAT = 3'd3,
    GAP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TGT_LO   = 2'd0,
    TGT_STAT = 2'd1,
    TGT_END  = 2'd2
  } target_t;

  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  target_t     tgt_q, tgt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] active_q, active_d;
  logic [19:0] pend_data_q, pend_data_d;
  logic        pend_q, pend_d;
  logic        lost_q, lost_d;
  logic [19:0] capture;
  logic        end_of_frame;
  logic        parity_bit;
  logic [9:0]  out_d;

  assign capture = {result, flags};

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    lost_d       = lost_q;
    end_of_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (done) begin
          active_d = capture;
          state_d  = HI;
        end
      end
      HI: begin
        if (HAS_GAP) begin
          state_d = GAP;
          tgt_d   = TGT_LO;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = LO;
        end
      end
      LO: begin
        if (HAS_GAP) begin
          state_d = GAP;
          tgt_d   = TGT_STAT;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = STAT;
        end
      end
      STAT: begin
        if (HAS_GAP) begin
          state_d = GAP;
          tgt_d   = TGT_END;
          cnt_d   = GAP_LOAD;
        end else begin
          end_of_frame = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          case (tgt_q)
            TGT_LO:   state_d = LO;
            TGT_STAT: state_d = STAT;
            default:  end_of_frame = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A done on the closing cycle chains straight into the next frame.
    if (end_of_frame) begin
      if (pend_q) begin
        active_d = pend_data_q;
        state_d  = HI;
        pend_d   = done;
        if (done) pend_data_d = capture;
      end else if (done) begin
        active_d = capture;
        state_d  = HI;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q != IDLE && done) begin
      if (!pend_q) begin
        pend_d      = 1'b1;
        pend_data_d = capture;
      end else begin
        lost_d = 1'b1;
      end
    end
  end

`ifdef OUT_PARITY_EN
  assign parity_bit = ^active_d[19:4];
`else
  assign parity_bit = 1'b0;
`endif

  // Output is formed from the next state so the register shows the beat
  // of the state being entered.
  always_comb begin
    out_d = 10'h000;
    case (state_d)
      HI:      out_d = {active_d[19:12], 2'b01};
      LO:      out_d = {active_d[11:4], 2'b10};
      STAT:    out_d = {active_d[3:0], 3'b000, parity_bit, 2'b11};
      default: out_d = 10'h000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_q       <= TGT_LO;
      cnt_q       <= 4'd0;
      active_q    <= 20'h0;
      pend_data_q <= 20'h0;
      pend_q      <= 1'b0;
      lost_q      <= 1'b0;
      out         <= 10'h000;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      lost_q      <= lost_d;
      out         <= out_d;
      busy        <= (state_d != IDLE);
    end
  end

  assign pending = pend_q;
  assign lost    = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_output_16.sv
// ============================================================================
// Module   : tb_output_16
// Purpose  : Self-checking bench for output_16 with three gap settings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] result  [3];
  logic [3:0]  flags   [3];
  logic        done    [3];
  logic [9:0]  out     [3];
  logic        busy    [3];
  logic        pending [3];
  logic        lost    [3];

  int checks = 0;
  int errors = 0;

  // reference model state: one active frame, one pending slot, sticky loss
  bit          m_act [3];
  int          m_pos [3];
  logic [19:0] m_afr [3];
  logic [19:0] m_pfr [3];
  bit          m_pv  [3];
  bit          m_lost[3];

  always #5 clock = ~clock;

  function automatic int gap_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    output_16 #(.GAP_CYCLES(gap_of(g))) u_dut (
      .clock   (clock),
      .reset   (reset),
      .result  (result[g]),
      .flags   (flags[g]),
      .done    (done[g]),
      .out     (out[g]),
      .busy    (busy[g]),
      .pending (pending[g]),
      .lost    (lost[g])
    );
  end

  function automatic logic [9:0] status_of(logic [19:0] fr);
    logic p;
`ifdef OUT_PARITY_EN
    p = ^fr[19:4];
`else
    p = 1'b0;
`endif
    return {fr[3:0], 3'b000, p, 2'b11};
  endfunction

  function automatic logic [9:0] model_out(int k);
    int g;
    g = gap_of(k);
    if (!m_act[k]) return 10'h000;
    if ((m_pos[k] % (g + 1)) != 0) return 10'h000;
    case (m_pos[k] / (g + 1))
      0:       return {m_afr[k][19:12], 2'b01};
      1:       return {m_afr[k][11:4], 2'b10};
      default: return status_of(m_afr[k]);
    endcase
  endfunction

  task automatic model_step(int k, bit d, logic [19:0] fr);
    int len;
    len = 3 + 3 * gap_of(k);
    if (!m_act[k]) begin
      if (d) begin
        m_act[k] = 1; m_pos[k] = 0; m_afr[k] = fr;
      end
    end else if (m_pos[k] == len - 1) begin
      if (m_pv[k]) begin
        m_afr[k] = m_pfr[k]; m_pos[k] = 0; m_pv[k] = d;
        if (d) m_pfr[k] = fr;
      end else if (d) begin
        m_afr[k] = fr; m_pos[k] = 0;
      end else begin
        m_act[k] = 0;
      end
    end else begin
      m_pos[k]++;
      if (d) begin
        if (!m_pv[k]) begin
          m_pv[k] = 1; m_pfr[k] = fr;
        end else begin
          m_lost[k] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(int k, logic [15:0] r, logic [3:0] f, logic d);
    result[k] = r; flags[k] = f; done[k] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 0; m_pos[k] = 0; m_pv[k] = 0; m_lost[k] = 0;
      m_afr[k] = '0; m_pfr[k] = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out[k] !== 10'h000 || busy[k] !== 1'b0 || pending[k] !== 1'b0 || lost[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state k=%0d got out=%h busy=%b pend=%b lost=%b want 000/0/0/0",
                 k, out[k], busy[k], pending[k], lost[k]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [9:0] exp [6];
    exp = '{10'h295, 10'h000, 10'h16A, 10'h000, 10'h083, 10'h000};
    drive(0, 16'hA55A, 4'b0010, 1'b1);
    tick();
    done[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out[0] !== exp[i] || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL basic_beat%0d got out=%h busy=%b want out=%h busy=1", i, out[0], busy[0], exp[i]);
      end
      tick();
    end
    checks++;
    if (out[0] !== 10'h000 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got out=%h busy=%b want 000/0", out[0], busy[0]);
    end
  endtask

  task automatic test_parity();
    logic [9:0] want;
`ifdef OUT_PARITY_EN
    want = 10'h007;
`else
    want = 10'h003;
`endif
    drive(1, 16'h0001, 4'h0, 1'b1);
    tick();
    done[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (out[1] !== want) begin
      errors++;
      $display("FAIL parity_status got %h want %h", out[1], want);
    end
    tick();
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_busy got %b want 0", busy[1]);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 16'h1234, 4'h0, 1'b1);
    tick();
    done[0] = 1'b0;
    tick();
    drive(0, 16'hBEEF, 4'h5, 1'b1);
    tick();
    done[0] = 1'b0;
    for (int pos = 2; pos <= 5; pos++) begin
      checks++;
      if (pending[0] !== 1'b1 || lost[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pending pos=%0d got pend=%b lost=%b want 1/0", pos, pending[0], lost[0]);
      end
      tick();
    end
    checks++;
    if (out[0] !== 10'h2F9 || pending[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_hi got out=%h pend=%b busy=%b want 2F9/0/1", out[0], pending[0], busy[0]);
    end
    tick();
    tick();
    checks++;
    if (out[0] !== 10'h3BE) begin
      errors++;
      $display("FAIL b2b_second_lo got %h want 3BE", out[0]);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy[0] !== 1'b0 || lost[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got busy=%b lost=%b want 0/0", busy[0], lost[0]);
    end
  endtask

  task automatic test_lost();
    int hi_seen;
    logic [7:0] hi_byte;
    hi_seen = 0;
    hi_byte = 8'h00;
    drive(2, 16'h1111, 4'h1, 1'b1);
    tick();
    checks++;
    if (out[2] !== 10'h045) begin
      errors++;
      $display("FAIL lost_first_hi got %h want 045", out[2]);
    end
    drive(2, 16'h2222, 4'h2, 1'b1);
    tick();
    drive(2, 16'h3333, 4'h3, 1'b1);
    tick();
    done[2] = 1'b0;
    checks++;
    if (lost[2] !== 1'b1 || pending[2] !== 1'b1) begin
      errors++;
      $display("FAIL lost_flag got lost=%b pend=%b want 1/1", lost[2], pending[2]);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out[2][1:0] == 2'b01) begin
        hi_seen++;
        hi_byte = out[2][9:2];
      end
    end
    checks++;
    if (hi_seen != 1 || hi_byte !== 8'h22 || busy[2] !== 1'b0 || lost[2] !== 1'b1) begin
      errors++;
      $display("FAIL lost_frames got extra_frames=%0d hi=%h busy=%b lost=%b want 1/22/0/1",
               hi_seen, hi_byte, busy[2], lost[2]);
    end
  endtask

  task automatic test_gap0();
    logic [9:0] exp [4];
    exp = '{10'h3FD, 10'h002, 10'h3C3, 10'h000};
    drive(1, 16'hFF00, 4'hF, 1'b1);
    tick();
    done[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out[1] !== exp[i] || busy[1] !== (i < 3)) begin
        errors++;
        $display("FAIL gap0_beat%0d got out=%h busy=%b want out=%h busy=%b", i, out[1], busy[1], exp[i], i < 3);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp [6];
    exp = '{10'h295, 10'h000, 10'h16A, 10'h000, 10'h083, 10'h000};
    drive(0, 16'h5678, 4'h0, 1'b1);
    tick();
    drive(0, 16'h9ABC, 4'h0, 1'b1);
    tick();
    drive(0, 16'hDEF0, 4'h0, 1'b1);
    tick();
    done[0] = 1'b0;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k += 2) begin
      checks++;
      if (out[k] !== 10'h000 || busy[k] !== 1'b0 || pending[k] !== 1'b0 || lost[k] !== 1'b0) begin
        errors++;
        $display("FAIL midreset k=%0d got out=%h busy=%b pend=%b lost=%b want 000/0/0/0",
                 k, out[k], busy[k], pending[k], lost[k]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    drive(0, 16'hA55A, 4'b0010, 1'b1);
    tick();
    done[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out[0] !== exp[i]) begin
        errors++;
        $display("FAIL midreset_frame beat%0d got %h want %h", i, out[0], exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          d  [3];
    logic [19:0] fr [3];
    logic [9:0]  w;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        d[k]  = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
        fr[k] = 20'($urandom);
        drive(k, fr[k][19:4], fr[k][3:0], d[k]);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        model_step(k, d[k], fr[k]);
        w = model_out(k);
        checks++;
        if (out[k] !== w) begin
          errors++;
          $display("FAIL rand_out k=%0d cyc=%0d got %h want %h", k, cyc, out[k], w);
        end
        checks++;
        if (busy[k] !== m_act[k] || pending[k] !== m_pv[k] || lost[k] !== m_lost[k]) begin
          errors++;
          $display("FAIL rand_flags k=%0d cyc=%0d got busy=%b pend=%b lost=%b want %b/%b/%b",
                   k, cyc, busy[k], pending[k], lost[k], m_act[k], m_pv[k], m_lost[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) done[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drive(k, 16'h0000, 4'h0, 1'b0);
    #1;
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_lost();
    test_gap0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
